fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 5-stage RV32IM pipeline, directly upstream of the decode stage. Owns the program counter, drives a synchronous (1-cycle read latency) instruction memory, and presents `instruction`/`pc`/`valid` to decode. Handles hazard-unit stalls with an internal hold buffer and execute-stage redirects (taken branch/jump) with a one-cycle bubble.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, instruction driven whenever `valid`=0 (ADDI x0,x0,0)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  1  hazard unit: hold current output, freeze PC
- `redirect_valid`  in  1  execute: taken branch/jump this cycle
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (treated as 00)
- `imem_en`  out  1  memory read enable
- `imem_addr`  out  32  memory read address
- `imem_rdata`  in  32  read data, valid the cycle after `imem_en`=1
- `instruction`  out  32  instruction to decode
- `pc`  out  32  PC of `instruction`
- `valid`  out  1  `instruction` is real, not a bubble

## Operation
- Registers: `fetch_pc` (next address), `req_pc` (address of data on `imem_rdata`), `req_valid`, `hold_instr`, `state`.
- States: IDLE (reset, nothing in flight), RUN, HOLD (stalled, output taken from `hold_instr`).
- Address select: `redirect_valid` ? `{redirect_pc[31:2],2'b00}` : `fetch_pc`. `imem_en` = !rst && (redirect_valid || !stall).
- Output: `pc`=`req_pc`; `valid`=`req_valid` && !`redirect_valid`; `instruction`= !valid ? NOP_INSTR : (state==HOLD ? `hold_instr` : `imem_rdata`).
- Priority per edge: rst > redirect > stall > normal.
- rst: `fetch_pc`<=RESET_PC, `req_pc`<=RESET_PC, `req_valid`<=0, `hold_instr`<=NOP_INSTR, state<=IDLE.
- Redirect: `req_pc`<=target, `req_valid`<=1, `fetch_pc`<=target+4, state<=RUN, hold buffer discarded. Redirect overrides a simultaneous stall.
- Normal (no stall): `req_pc`<=`fetch_pc`, `req_valid`<=1, `fetch_pc`<=`fetch_pc`+4, state<=RUN.
- Stall: `fetch_pc`, `req_pc`, `req_valid` frozen. From RUN: `hold_instr`<=`imem_rdata`, state<=HOLD. In HOLD: unchanged. In IDLE: stays IDLE.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: `valid`=0, `instruction`=NOP_INSTR, `pc`=RESET_PC, `imem_en`=0, `imem_addr`=RESET_PC.
- First cycle after rst release: `imem_en`=1, `imem_addr`=RESET_PC, `valid`=0. Next cycle: `valid`=1, `pc`=RESET_PC.
- Fetch latency 1 cycle; throughput 1 instr/cycle when unstalled.
- Stall: outputs stable for every stalled cycle, starting the cycle `stall` rises; on the first cycle with `stall`=0, output is still the held instruction (consumed by decode at that edge), memory re-reads `fetch_pc`, next instruction appears the following cycle.
- Redirect cycle: `valid`=0 (wrong-path instruction suppressed); target instruction valid next cycle. Penalty: 1 bubble from fetch; younger stages flushed by hazard unit.

## Configuration
- `FETCH_PERF_EN` defined: add outputs `perf_fetched` (32, instructions delivered: `valid`&&!`stall`) and `perf_bubbles` (32, cycles with `valid`=0 or `stall`=1, excluding `rst`); both reset to 0, wrap modulo 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package/header: `NOP_INSTR` encoding, default `RESET_PC`, fetch state encoding (IDLE/RUN/HOLD), `XLEN`=32.
- One sub-module: `fetch_hold_buffer` (`hold_instr` + HOLD state capture/select); PC logic stays in `fetch_stage`.

## Test plan
- Reset, memory word n = 0x1000_0000+n: after release, `valid`=1 next cycle with pc 0x0, 0x4, 0x8 on consecutive cycles, instructions 0x1000_0000/1/2.
- Stall 3 cycles while pc=0x8 is output: `pc`=0x8, `instruction`=0x1000_0002 stable for 4 cycles (3 stalled + release); next cycle pc=0xC; memory output changed during stall has no effect.
- Redirect to 0x40 while pc=0x10 is output: that cycle `valid`=0 and `instruction`=0x0000_0013; next cycle pc=0x40, then 0x44.
- Redirect to 0x80 with `stall`=1 in HOLD: redirect wins; next cycle pc=0x80 valid; `redirect_pc`=0x83 behaves as 0x80.
- RESET_PC=32'hFFFF_FFFC: fetched pcs 0xFFFF_FFFC then 0x0; `rst` asserted mid-stream returns outputs to reset values on the next edge.
- With `FETCH_PERF_EN`: 10 unstalled fetches, 2 stall cycles, 1 redirect -> `perf_fetched`=10, `perf_bubbles`=4 (initial bubble + 2 stalls + redirect).

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32 instruction fetch stage: widths, NOP encoding,
// default reset PC and the fetch state encoding.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    // ADDI x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buffer.sv
// Stall hold buffer for the fetch stage: captures the memory word when a stall
// begins and selects between held and live instruction data.
module fetch_hold_buffer
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic            stall,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_sel
);

    fetch_state_e    state;
    logic [XLEN-1:0] hold_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            state      <= ST_RUN;
            hold_instr <= NOP_INSTR;
        end else if (stall) begin
            // Memory is not re-read while stalled, so its output may drift; latch it once.
            if (state == ST_RUN) begin
                state      <= ST_HOLD;
                hold_instr <= imem_rdata;
            end
        end else begin
            state <= ST_RUN;
        end
    end

    assign instr_sel = (state == ST_HOLD) ? hold_instr : imem_rdata;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, synchronous imem interface, stall hold, redirect bubble.
// Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc,
    output logic            valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles
`endif
);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            req_valid;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] instr_sel;
    logic            unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request stage: address select toward synchronous memory
    assign imem_en   = !rst && (redirect_valid || !stall);
    assign imem_addr = redirect_valid ? redirect_target : fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            req_valid <= 1'b0;
        end else if (redirect_valid) begin
            req_pc    <= redirect_target;
            req_valid <= 1'b1;
            fetch_pc  <= redirect_target + XLEN'(4);
        end else if (!stall) begin
            req_pc    <= fetch_pc;
            req_valid <= 1'b1;
            fetch_pc  <= fetch_pc + XLEN'(4);
        end
    end

    fetch_hold_buffer u_hold (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .stall         (stall),
        .imem_rdata    (imem_rdata),
        .instr_sel     (instr_sel)
    );

    // Response stage: data returned for req_pc; a redirect squashes it
    assign pc          = req_pc;
    assign valid       = req_valid && !redirect_valid;
    assign instruction = valid ? instr_sel : NOP_INSTR;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (valid && !stall)
                perf_fetched <= perf_fetched + 32'd1;
            if (!valid || stall)
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a behavioural synchronous instruction memory.
// Define FETCH_PERF_EN to also exercise the performance counters.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // main instance, RESET_PC = 0
    logic        rst = 1'b1, stall = 1'b0, redirect_valid = 1'b0, corrupt = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_en;
    logic [31:0] imem_addr, imem_rdata = '0, instruction, pc;
    logic        valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    // wrap instance, RESET_PC = 0xFFFF_FFFC
    logic        rst_w = 1'b1;
    logic        imem_en_w;
    logic [31:0] imem_addr_w, imem_rdata_w = '0, instruction_w, pc_w;
    logic        valid_w;
    logic [31:0] perf_dummy_f, perf_dummy_b;

    fetch_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc            (pc),
        .valid         (valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk           (clk),
        .rst           (rst_w),
        .stall         (1'b0),
        .redirect_valid(1'b0),
        .redirect_pc   (32'h0),
        .imem_en       (imem_en_w),
        .imem_addr     (imem_addr_w),
        .imem_rdata    (imem_rdata_w),
        .instruction   (instruction_w),
        .pc            (pc_w),
        .valid         (valid_w)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_dummy_f),
        .perf_bubbles  (perf_dummy_b)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    always @(posedge clk) begin
        if (imem_en)
            imem_rdata <= mem_word(imem_addr);
        else if (corrupt)
            imem_rdata <= 32'hDEAD_BEEF;
        if (imem_en_w)
            imem_rdata_w <= mem_word(imem_addr_w);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one cycle, drive inputs, then let combinational outputs settle
    task automatic cyc(input logic s, input logic rv, input logic [31:0] rpc, input logic cor);
        @(posedge clk);
        #1;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        corrupt        = cor;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] p, input logic [31:0] ins);
        chk({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
        chk({tag, ".pc"}, pc, p);
        chk({tag, ".instr"}, instruction, ins);
    endtask

    initial begin
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst.valid", {31'b0, valid}, 32'd0);
        chk("rst.instr", instruction, 32'h0000_0013);
        chk("rst.pc", pc, 32'h0);
        chk("rst.en", {31'b0, imem_en}, 32'd0);
        chk("rst.addr", imem_addr, 32'h0);

        // release reset: first request goes out, no valid yet
        @(posedge clk); #1; rst = 1'b0; #1;
        chk("c0.en", {31'b0, imem_en}, 32'd1);
        chk("c0.addr", imem_addr, 32'h0);
        chk("c0.valid", {31'b0, valid}, 32'd0);

        cyc(0, 0, 0, 0); chk_out("c1", 1, 32'h0, 32'h1000_0000);
        cyc(0, 0, 0, 0); chk_out("c2", 1, 32'h4, 32'h1000_0001);

        // three stalled cycles with memory output scrambled, then release
        cyc(1, 0, 0, 1); chk_out("st0", 1, 32'h8, 32'h1000_0002);
        chk("st0.en", {31'b0, imem_en}, 32'd0);
        cyc(1, 0, 0, 1); chk_out("st1", 1, 32'h8, 32'h1000_0002);
        cyc(1, 0, 0, 1); chk_out("st2", 1, 32'h8, 32'h1000_0002);
        cyc(0, 0, 0, 0); chk_out("strel", 1, 32'h8, 32'h1000_0002);
        chk("strel.addr", imem_addr, 32'hC);
        chk("strel.en", {31'b0, imem_en}, 32'd1);
        cyc(0, 0, 0, 0); chk_out("st.next", 1, 32'hC, 32'h1000_0003);

        // redirect while pc=0x10 is presented
        cyc(0, 1, 32'h40, 0); chk_out("rd0", 0, 32'h10, 32'h0000_0013);
        chk("rd0.addr", imem_addr, 32'h40);
        cyc(0, 0, 0, 0); chk_out("rd1", 1, 32'h40, 32'h1000_0010);
        cyc(1, 0, 0, 0); chk_out("rd2", 1, 32'h44, 32'h1000_0011);

        // redirect in HOLD with stall still high; unaligned target
        cyc(1, 1, 32'h83, 0); chk("rdh.valid", {31'b0, valid}, 32'd0);
        chk("rdh.en", {31'b0, imem_en}, 32'd1);
        chk("rdh.addr", imem_addr, 32'h80);
        cyc(0, 0, 0, 0); chk_out("rdh1", 1, 32'h80, 32'h1000_0020);
        cyc(0, 0, 0, 0); chk_out("rdh2", 1, 32'h84, 32'h1000_0021);

        // reset mid-stream
        @(posedge clk); #1; rst = 1'b1; #1;
        chk("mrst.en", {31'b0, imem_en}, 32'd0);
        cyc(0, 0, 0, 0); chk_out("mrst", 0, 32'h0, 32'h0000_0013);
        chk("mrst.addr", imem_addr, 32'h0);

        // PC wrap on the second instance
        chk("wrap.rstaddr", imem_addr_w, 32'hFFFF_FFFC);
        @(posedge clk); #1; rst_w = 1'b0; #1;
        chk("wrap.c0.valid", {31'b0, valid_w}, 32'd0);
        @(posedge clk); #2;
        chk("wrap.c1.valid", {31'b0, valid_w}, 32'd1);
        chk("wrap.c1.pc", pc_w, 32'hFFFF_FFFC);
        chk("wrap.c1.instr", instruction_w, 32'h4FFF_FFFF);
        @(posedge clk); #2;
        chk("wrap.c2.pc", pc_w, 32'h0);
        chk("wrap.c2.instr", instruction_w, 32'h1000_0000);

`ifdef FETCH_PERF_EN
        // 10 delivered, bubbles: initial + 2 stalls + redirect
        chk("perf.rst.f", perf_fetched, 32'd0);
        chk("perf.rst.b", perf_bubbles, 32'd0);
        @(posedge clk); #1; rst = 1'b0; #1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h100, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("perf.fetched", perf_fetched, 32'd10);
        chk("perf.bubbles", perf_bubbles, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
